mc_port_alloc_pipe: RTL and testbench
=====================================

Name: mc_port_alloc_pipe

Overview:
- Parametrised, pipelined successor to the 4-channel combinational multicast port allocator used in the bufferless multicast router.
- Allocates NUM_OUT output ports to NUM_CH rank-ordered input channels. Channel 0 has the highest rank.
- Unicast flits get one port: productive if available, otherwise deflected. Multicast flits get several productive ports, limited by a copy budget.
- Adds what the combinational version lacks: a registered valid/ready elastic pipeline, per-channel valid, budget-exhaustion fallback, a deflection statistics counter and a sticky no-port error.

Parameters:
- NUM_CH, 4: number of input channels, in rank order.
- NUM_OUT, 4: number of allocatable output ports (local port excluded); NUM_OUT >= NUM_CH.
- BUD_W, 3: width of the copy budget.
- LAT, 2: pipeline depth, 1 or 2 register stages.
- CNT_W, 16: width of the deflection counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request bundle valid.
- in_ready  out  1  bundle accepted when in_valid & in_ready.
- in_ch_vld  in  NUM_CH  channel i holds a flit.
- in_mc  in  NUM_CH  channel i flit is multicast.
- in_ppv  in  NUM_CH*NUM_OUT  productive port vector; channel i occupies bits [i*NUM_OUT +: NUM_OUT].
- in_budget  in  BUD_W  multicast copy budget for this bundle.
- out_valid  out  1  allocation result valid.
- out_ready  in  1  downstream accepts result.
- out_apv  out  NUM_CH*NUM_OUT  allocated port vector per channel, same packing as in_ppv.
- out_defl  out  NUM_CH  channel i was deflected (received a non-productive port).
- out_budget  out  BUD_W  budget remaining after allocation.
- defl_cnt  out  CNT_W  saturating count of deflected flits.
- cnt_clr  in  1  synchronous clear of defl_cnt.
- err_noport  out  1  sticky: a valid channel received no port.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valids 0, out_valid=0, out_apv=0, out_defl=0, out_budget=0, defl_cnt=0, err_noport=0, in_ready=1. Reset mid-operation discards all in-flight bundles.
- Pipeline, LAT=2:
  - Stage 1 registers the inputs.
  - Stage 2 computes the allocation and registers the result.
  - Result appears 2 cycles after acceptance when out_ready is held high.
- Pipeline, LAT=1: the allocation is computed from the inputs and registered; result appears 1 cycle after acceptance.
- Elastic rule: a stage loads when it is empty or its content is leaving that cycle.
  - in_ready = ~stage1_valid | stage1_advances.
  - Full throughput of 1 bundle/cycle when out_ready is 1.
  - While out_valid & ~out_ready, the registered outputs are held stable and nothing is lost or duplicated.
- Allocation order: channel 0 to NUM_CH-1. avail starts as all ones; bud starts as in_budget.
  - Channel with in_ch_vld=0: apv=0, defl=0.
  - Unicast, or multicast with bud=0:
    - p = in_ppv & avail. If p≠0, grant the lowest set bit of p, defl=0.
    - Otherwise grant the lowest set bit of avail, defl=1.
  - Multicast with bud>0:
    - p = in_ppv & avail. If p≠0, grant the lowest min(popcount(p), bud) set bits of p, and bud -= number granted.
    - If p=0, grant the lowest set bit of avail, defl=1, bud unchanged.
  - After each channel: avail &= ~apv.
  - A valid channel with avail=0: apv=0, defl=0, err_noport set and held until reset.
- out_budget is the final bud. It never underflows and saturates at 0.
- defl_cnt:
  - Increments by popcount(out_defl) on each output handshake (out_valid & out_ready), saturating at 2^CNT_W-1.
  - cnt_clr has priority and sets the count to 0 on the same edge, ignoring any concurrent increment.
- Channels with an all-zero ppv that are valid are treated as deflected.

Test Plan:
- Reset mid-stream: assert rst_n=0 while two bundles are in flight. Required: out_valid=0 immediately; after release, no stale result appears; in_ready=1.
- Unicast, no conflict, NUM_CH=NUM_OUT=4: ppv = 0001, 0010, 0100, 1000, all unicast, out_ready=1. Required: apv equals ppv, out_defl=0000, result appears 2 cycles after acceptance.
- Unicast conflict: all four channels have ppv=0001. Required: apv = 0001, 0010, 0100, 1000; out_defl=1110; defl_cnt increments by 3.
- Multicast budget: ch0 mc with ppv=1111, in_budget=2, ch1 unicast with ppv=0001. Required: ch0 apv=0011, ch1 apv=0100 with defl=1, out_budget=0.
- Backpressure: stream 5 bundles with out_ready toggling 1,0,0,1,... Required: every bundle is output exactly once, in order; outputs are stable while stalled; in_ready drops when both stages are full.
- Counter: preload near saturation with repeated deflections. Required: defl_cnt holds at 0xFFFF; cnt_clr together with a deflecting handshake gives 0.

Source files
------------

// File: rtl/mc_port_alloc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mc_port_alloc_pipe
// Description : Pipelined multicast output-port allocator. Grants output
//               ports to rank-ordered input channels (channel 0 first),
//               with an elastic valid/ready pipeline, a multicast copy
//               budget, a saturating deflection counter and a sticky
//               no-port error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_port_alloc_pipe #(
  parameter int NUM_CH  = 4,
  parameter int NUM_OUT = 4,
  parameter int BUD_W   = 3,
  parameter int LAT     = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH-1:0]          in_ch_vld,
  input  logic [NUM_CH-1:0]          in_mc,
  input  logic [NUM_CH*NUM_OUT-1:0]  in_ppv,
  input  logic [BUD_W-1:0]           in_budget,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*NUM_OUT-1:0]  out_apv,
  output logic [NUM_CH-1:0]          out_defl,
  output logic [BUD_W-1:0]           out_budget,
  output logic [CNT_W-1:0]           defl_cnt,
  input  logic                       cnt_clr,
  output logic                       err_noport
);

  localparam int PV_W  = NUM_CH * NUM_OUT;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [BUD_W-1:0]   c_BUD_ONE = BUD_W'(1);
  localparam logic [NUM_OUT-1:0] c_OUT_ONE = NUM_OUT'(1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;

  // Allocation source (either stage-1 registers or the raw inputs)
  logic              w_src_valid;
  logic [NUM_CH-1:0] w_src_ch_vld;
  logic [NUM_CH-1:0] w_src_mc;
  logic [PV_W-1:0]   w_src_ppv;
  logic [BUD_W-1:0]  w_src_budget;

  // Output stage registers
  logic              r_out_valid;
  logic [PV_W-1:0]   r_out_apv;
  logic [NUM_CH-1:0] r_out_defl;
  logic [BUD_W-1:0]  r_out_budget;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  // Output stage may load when empty or when its content is being taken
  logic w_out_load;
  assign w_out_load = ~r_out_valid | out_ready;

  generate
    if (LAT == 2) begin : g_two_stage
      logic              r_s1_valid;
      logic [NUM_CH-1:0] r_s1_ch_vld;
      logic [NUM_CH-1:0] r_s1_mc;
      logic [PV_W-1:0]   r_s1_ppv;
      logic [BUD_W-1:0]  r_s1_budget;
      logic              w_s1_adv;

      assign w_s1_adv = r_s1_valid & w_out_load;
      assign in_ready = ~r_s1_valid | w_s1_adv;

      // Stage 1: capture the raw request bundle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_valid  <= 1'b0;
          r_s1_ch_vld <= '0;
          r_s1_mc     <= '0;
          r_s1_ppv    <= '0;
          r_s1_budget <= '0;
        end else if (in_ready) begin
          r_s1_valid <= in_valid;
          if (in_valid) begin
            r_s1_ch_vld <= in_ch_vld;
            r_s1_mc     <= in_mc;
            r_s1_ppv    <= in_ppv;
            r_s1_budget <= in_budget;
          end
        end
      end

      assign w_src_valid  = r_s1_valid;
      assign w_src_ch_vld = r_s1_ch_vld;
      assign w_src_mc     = r_s1_mc;
      assign w_src_ppv    = r_s1_ppv;
      assign w_src_budget = r_s1_budget;
    end else begin : g_one_stage
      assign in_ready     = w_out_load;
      assign w_src_valid  = in_valid;
      assign w_src_ch_vld = in_ch_vld;
      assign w_src_mc     = in_mc;
      assign w_src_ppv    = in_ppv;
      assign w_src_budget = in_budget;
    end
  endgenerate

  // Allocation working state
  logic [PV_W-1:0]    w_alloc_apv;
  logic [NUM_CH-1:0]  w_alloc_defl;
  logic [BUD_W-1:0]   w_alloc_bud;
  logic               w_noport;
  logic [NUM_OUT-1:0] w_avail;
  logic [NUM_OUT-1:0] w_prod;
  logic [NUM_OUT-1:0] w_grant;

  // Rank-ordered allocation: each channel takes from what higher ranks left
  always_comb begin
    w_alloc_apv  = '0;
    w_alloc_defl = '0;
    w_alloc_bud  = w_src_budget;
    w_noport     = 1'b0;
    w_avail      = '1;
    w_prod       = '0;
    w_grant      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_grant = '0;
      w_prod  = w_src_ppv[i*NUM_OUT +: NUM_OUT] & w_avail;
      if (w_src_ch_vld[i]) begin
        if (w_avail == '0) begin
          w_noport = 1'b1;
        end else if (w_src_mc[i] && (w_alloc_bud != '0) && (w_prod != '0)) begin
          // Multicast copies: lowest productive ports until budget runs out
          for (int j = 0; j < NUM_OUT; j++) begin
            if (w_prod[j] && (w_alloc_bud != '0)) begin
              w_grant[j]  = 1'b1;
              w_alloc_bud = w_alloc_bud - c_BUD_ONE;
            end
          end
        end else if (w_prod != '0) begin
          w_grant = w_prod & (~w_prod + c_OUT_ONE);
        end else begin
          // No productive port left: deflect onto the lowest free port
          w_grant         = w_avail & (~w_avail + c_OUT_ONE);
          w_alloc_defl[i] = 1'b1;
        end
      end
      w_alloc_apv[i*NUM_OUT +: NUM_OUT] = w_grant;
      w_avail = w_avail & ~w_grant;
    end
  end

  // Output stage: register the allocation result, hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_apv    <= '0;
      r_out_defl   <= '0;
      r_out_budget <= '0;
    end else if (w_out_load) begin
      r_out_valid <= w_src_valid;
      if (w_src_valid) begin
        r_out_apv    <= w_alloc_apv;
        r_out_defl   <= w_alloc_defl;
        r_out_budget <= w_alloc_bud;
      end
    end
  end

  // Number of deflected channels in the result currently presented
  logic [SUM_W-1:0] w_defl_pop;
  logic [SUM_W-1:0] w_cnt_sum;

  // Popcount of the registered deflection vector
  always_comb begin
    w_defl_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_defl_pop = w_defl_pop + SUM_W'(r_out_defl[i]);
    end
  end

  assign w_cnt_sum = {1'b0, r_cnt} + w_defl_pop;

  // Saturating deflection counter; clear wins over a concurrent increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (r_out_valid && out_ready) begin
      r_cnt <= w_cnt_sum[CNT_W] ? c_CNT_MAX : w_cnt_sum[CNT_W-1:0];
    end
  end

  // Sticky error: a valid channel found every port already taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_out_load && w_src_valid && w_noport) begin
      r_err <= 1'b1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_apv    = r_out_apv;
  assign out_defl   = r_out_defl;
  assign out_budget = r_out_budget;
  assign defl_cnt   = r_cnt;
  assign err_noport = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mc_port_alloc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_port_alloc_pipe
// Description : Directed self-checking bench for mc_port_alloc_pipe
//               (NUM_CH=NUM_OUT=4, BUD_W=3, LAT=2, CNT_W=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_port_alloc_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ch_vld;
  logic [3:0]  in_mc;
  logic [15:0] in_ppv;
  logic [2:0]  in_budget;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_apv;
  logic [3:0]  out_defl;
  logic [2:0]  out_budget;
  logic [15:0] defl_cnt;
  logic        cnt_clr;
  logic        err_noport;

  int vectors = 0;
  int miscompares = 0;

  mc_port_alloc_pipe #(
    .NUM_CH(4), .NUM_OUT(4), .BUD_W(3), .LAT(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ch_vld(in_ch_vld), .in_mc(in_mc), .in_ppv(in_ppv), .in_budget(in_budget),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_apv(out_apv), .out_defl(out_defl), .out_budget(out_budget),
    .defl_cnt(defl_cnt), .cnt_clr(cnt_clr), .err_noport(err_noport)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one bundle into an empty pipe and capture the result it produces
  task automatic run_one(input logic [3:0] vld, input logic [3:0] mc,
                         input logic [15:0] ppv, input logic [2:0] bud,
                         output logic [15:0] apv, output logic [3:0] defl,
                         output logic [2:0] bo, output int lat, output bit to);
    in_ch_vld = vld; in_mc = mc; in_ppv = ppv; in_budget = bud;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    to = !out_valid;
    apv = out_apv; defl = out_defl; bo = out_budget;
    tick();
  endtask

  task automatic test_reset();
    logic seen;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_apv !== 16'h0 ||
        out_defl !== 4'h0 || out_budget !== 3'h0 || defl_cnt !== 16'h0 ||
        err_noport !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ov=%b ir=%b apv=%h defl=%b bud=%0d cnt=%0d err=%b, want 0 1 0000 0000 0 0 0",
               out_valid, in_ready, out_apv, out_defl, out_budget, defl_cnt, err_noport);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // Two bundles in flight, then reset between edges
    out_ready = 1'b0;
    in_ch_vld = 4'hF; in_mc = 4'h0; in_ppv = 16'h8421; in_budget = 3'd1;
    in_valid = 1'b1;
    tick();
    in_ppv = 16'h1111;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_midstream: ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_stale: stale_seen=%b ir=%b, want 0 1", seen, in_ready);
    end
  endtask

  task automatic test_unicast();
    logic [15:0] a; logic [3:0] d; logic [2:0] b; int lat; bit to;
    run_one(4'hF, 4'h0, 16'h8421, 3'd3, a, d, b, lat, to);
    vectors++;
    if (to || a !== 16'h8421 || d !== 4'h0 || b !== 3'd3 || lat != 2) begin
      miscompares++;
      $display("FAIL unicast_free: to=%0b apv=%h defl=%b bud=%0d lat=%0d, want apv=8421 defl=0000 bud=3 lat=2",
               to, a, d, b, lat);
    end
    vectors++;
    if (defl_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL unicast_cnt: cnt=%0d, want 0", defl_cnt);
    end
  endtask

  task automatic test_conflict();
    logic [15:0] a; logic [3:0] d; logic [2:0] b; int lat; bit to;
    run_one(4'hF, 4'h0, 16'h1111, 3'd0, a, d, b, lat, to);
    vectors++;
    if (to || a !== 16'h8421 || d !== 4'b1110) begin
      miscompares++;
      $display("FAIL unicast_conflict: to=%0b apv=%h defl=%b, want apv=8421 defl=1110", to, a, d);
    end
    vectors++;
    if (defl_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL conflict_cnt: cnt=%0d, want 3", defl_cnt);
    end
  endtask

  task automatic test_mcast();
    logic [15:0] a; logic [3:0] d; logic [2:0] b; int lat; bit to;
    // ch0 mc 1111 budget 2 -> 0011; ch1 uni 0001 -> deflected to 0100
    run_one(4'b0011, 4'b0001, 16'h001F, 3'd2, a, d, b, lat, to);
    vectors++;
    if (to || a !== 16'h0043 || d !== 4'b0010 || b !== 3'd0) begin
      miscompares++;
      $display("FAIL mcast_budget: to=%0b apv=%h defl=%b bud=%0d, want apv=0043 defl=0010 bud=0", to, a, d, b);
    end
    vectors++;
    if (defl_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL mcast_cnt: cnt=%0d, want 4", defl_cnt);
    end
    // ch0 mc 0110 bud3 -> 0110 (bud 1); ch1 mc 1001 -> 0001 (bud 0);
    // ch2 mc 1000 with empty budget -> unicast rule 1000
    run_one(4'b0111, 4'b0111, 16'h0896, 3'd3, a, d, b, lat, to);
    vectors++;
    if (to || a !== 16'h0816 || d !== 4'b0000 || b !== 3'd0 || err_noport !== 1'b0) begin
      miscompares++;
      $display("FAIL mcast_partial: to=%0b apv=%h defl=%b bud=%0d err=%b, want apv=0816 defl=0000 bud=0 err=0",
               to, a, d, b, err_noport);
    end
  endtask

  task automatic test_zero_ppv();
    logic [15:0] a; logic [3:0] d; logic [2:0] b; int lat; bit to;
    // ch0 ppv 0000 -> 0001 defl; ch1 0001 -> 0010 defl; ch2 idle; ch3 1000
    run_one(4'b1011, 4'h0, 16'h8010, 3'd5, a, d, b, lat, to);
    vectors++;
    if (to || a !== 16'h8021 || d !== 4'b0011 || b !== 3'd5) begin
      miscompares++;
      $display("FAIL zero_ppv: to=%0b apv=%h defl=%b bud=%0d, want apv=8021 defl=0011 bud=5", to, a, d, b);
    end
    vectors++;
    if (defl_cnt !== 16'd6 || err_noport !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_ppv_cnt: cnt=%0d err=%b, want 6 0", defl_cnt, err_noport);
    end
  endtask

  task automatic test_noport();
    logic [15:0] a; logic [3:0] d; logic [2:0] b; int lat; bit to;
    // ch0 mc takes all four ports; ch1 and ch2 are left with nothing
    run_one(4'b0111, 4'b0001, 16'h001F, 3'd4, a, d, b, lat, to);
    vectors++;
    if (to || a !== 16'h000F || d !== 4'b0000 || b !== 3'd0 || err_noport !== 1'b1) begin
      miscompares++;
      $display("FAIL noport: to=%0b apv=%h defl=%b bud=%0d err=%b, want apv=000F defl=0000 bud=0 err=1",
               to, a, d, b, err_noport);
    end
    tick(); tick();
    vectors++;
    if (err_noport !== 1'b1 || defl_cnt !== 16'd6) begin
      miscompares++;
      $display("FAIL noport_sticky: err=%b cnt=%0d, want 1 6", err_noport, defl_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (err_noport !== 1'b0 || defl_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL noport_reset: err=%b cnt=%0d, want 0 0", err_noport, defl_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit saw_block = 1'b0;
    logic [15:0] held_apv = '0;
    logic [2:0]  held_bud = '0;
    logic [3:0]  onehot;
    logic [3:0]  exp_oh;
    in_ch_vld = 4'b0001; in_mc = 4'h0;
    while (got < 5 && cyc < 80) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 5);
      onehot    = 4'b0001 << (sent % 4);
      in_ppv    = {12'h000, onehot};
      in_budget = sent[2:0];
      @(negedge clk);
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_apv !== held_apv || out_budget !== held_bud) begin
          miscompares++;
          $display("FAIL stall_hold: ov=%b apv=%h bud=%0d, want 1 %h %0d", out_valid, out_apv, out_budget,
                   held_apv, held_bud);
        end
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        exp_oh = 4'b0001 << (got % 4);
        vectors++;
        if (out_apv !== {12'h000, exp_oh} || out_budget !== got[2:0] || out_defl !== 4'h0) begin
          miscompares++;
          $display("FAIL bp_order[%0d]: apv=%h bud=%0d defl=%b, want apv=%h bud=%0d defl=0000",
                   got, out_apv, out_budget, out_defl, {12'h000, exp_oh}, got[2:0]);
        end
        got++;
      end
      stalled  = out_valid && !out_ready;
      held_apv = out_apv;
      held_bud = out_budget;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got != 5 || sent != 5) begin
      miscompares++;
      $display("FAIL bp_count: got=%0d sent=%0d, want 5 5", got, sent);
    end
    vectors++;
    if (saw_block !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_in_ready: in_ready_dropped=%b, want 1", saw_block);
    end
    repeat (3) tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_dup: ov=%b, want 0", out_valid);
    end
  endtask

  task automatic test_counter();
    logic [15:0] a; logic [3:0] d; logic [2:0] b; int lat; bit to;
    int sent = 0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    vectors++;
    if (defl_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL cnt_clear: cnt=%0d, want 0", defl_cnt);
    end
    // 21844 conflict bundles at 3 deflections each -> 65532
    in_ch_vld = 4'hF; in_mc = 4'h0; in_ppv = 16'h1111; in_budget = 3'd0;
    out_ready = 1'b1; in_valid = 1'b1;
    while (sent < 21844) begin
      @(negedge clk);
      if (in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    vectors++;
    if (defl_cnt !== 16'd65532) begin
      miscompares++;
      $display("FAIL cnt_preload: cnt=%0d, want 65532", defl_cnt);
    end
    run_one(4'hF, 4'h0, 16'h1111, 3'd0, a, d, b, lat, to);
    vectors++;
    if (to || defl_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL cnt_reach_max: to=%0b cnt=%h, want FFFF", to, defl_cnt);
    end
    run_one(4'hF, 4'h0, 16'h1111, 3'd0, a, d, b, lat, to);
    vectors++;
    if (to || defl_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL cnt_saturate: to=%0b cnt=%h, want FFFF", to, defl_cnt);
    end
    // Clear on the same edge as a deflecting handshake
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    cnt_clr = 1'b1;
    vectors++;
    if (out_valid !== 1'b1 || out_defl !== 4'b1110) begin
      miscompares++;
      $display("FAIL clr_setup: ov=%b defl=%b, want 1 1110", out_valid, out_defl);
    end
    tick();
    cnt_clr = 1'b0;
    vectors++;
    if (defl_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL cnt_clr_priority: cnt=%0d, want 0", defl_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_ch_vld = '0; in_mc = '0; in_ppv = '0; in_budget = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    #12;
    test_reset();
    test_unicast();
    test_conflict();
    test_mcast();
    test_zero_ppv();
    test_noport();
    test_backpressure();
    test_counter();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
